axi4_frame_reader: RTL and testbench
====================================

Name: axi4_frame_reader

Overview:
- AXI4 read master; the read-side counterpart of the stream-to-DDR frame writer.
- Fetches one full frame (320x240 RGB565, 153600 bytes) from DDR at FRAME_BASE_ADDR in fixed 64-beat INCR bursts.
- Buffers the data in an internal synchronous FIFO and presents it as a 64-bit valid/ready stream to the HDMI output path.
- Issues a burst only when the FIFO has room for the whole burst, so R-channel data is never stalled.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI/stream data width (fixed at 64; other values unsupported)
BURST_BEATS, 64, beats per burst (ARLEN = BURST_BEATS-1)
FRAME_BYTES, 153600, bytes per frame (must be a multiple of BURST_BEATS*8)
FIFO_DEPTH, 256, FIFO entries (power of two, >= BURST_BEATS)

Ports:
clk_100Mhz  in  1  single clock for all logic
rst_n  in  1  synchronous active-low reset
start  in  1  frame request pulse; accepted only in IDLE
FRAME_BASE_ADDR  in  32  frame base byte address; sampled on accepted start
ARADDR  out  32  burst address
ARVALID  out  1  address valid
ARREADY  in  1  address ready
ARLEN  out  8  constant BURST_BEATS-1
ARSIZE  out  3  constant 3'b011
ARBURST  out  2  constant 2'b01 (INCR)
ARCACHE  out  4  constant 4'b0011
ARPROT  out  3  constant 3'b000
RDATA  in  64  read data
RVALID  in  1  read valid
RREADY  out  1  read ready
RLAST  in  1  last beat of burst
RRESP  in  2  read response
m_data  out  64  stream data (FIFO head, FWFT)
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts beat
m_sof  out  1  qualifies the first beat of the frame
m_last  out  1  qualifies the final beat of the frame (beat FRAME_BYTES/8-1)
busy  out  1  high from accepted start until the final R beat is received
reader_done  out  1  one-cycle pulse after the final R beat
rd_err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (rst_n low at a clock edge):
  - State returns to IDLE; ARVALID, RREADY, busy, reader_done, rd_err, m_sof and m_last go to 0.
  - ARADDR and offset go to 0; FIFO and output beat counter are flushed, so m_valid = 0.
  - Reset mid-burst aborts locally; the interconnect is reset alongside.
- States:
  - IDLE: start -> latch base, offset = 0, busy = 1, go to WAIT_SPACE.
  - WAIT_SPACE: when FIFO_DEPTH - count >= BURST_BEATS -> load ARADDR = base + offset, assert ARVALID, go to ADDR_SEND.
  - ADDR_SEND: hold ARVALID and ARADDR stable until ARREADY; on the handshake, drop ARVALID and go to DATA_RECV.
  - DATA_RECV: RREADY = 1 and every RVALID beat is pushed to the FIFO. On RVALID & RLAST:
    - if offset == FRAME_BYTES - BURST_BEATS*8 (153088): reader_done pulse, busy = 0, go to IDLE;
    - otherwise offset += BURST_BEATS*8 (512) and go to WAIT_SPACE.
- One burst outstanding maximum.
- RREADY is 0 outside DATA_RECV.
- Space is reserved before AR is issued, so a FIFO push never meets a full FIFO.
- start outside IDLE is ignored.
- The FIFO is not flushed by start; the previous frame's tail drains first.
- Stream side:
  - m_valid = !empty.
  - A pop occurs on m_valid & m_ready.
  - A simultaneous push and pop in one cycle keeps count unchanged.
  - Zero-latency FWFT head.
- Output beat counter: counts pops, wraps to 0 after beat FRAME_BYTES/8-1 (19199).
  - m_sof = m_valid & count == 0.
  - m_last = m_valid & count == 19199.
- Latency: the first m_valid appears 1 cycle after the first R beat is accepted.

Optional Feature:
- Macro: READER_ERR_CHECK_EN.
- When defined, rd_err sets (sticky until reset) on either of:
  - an accepted R beat with RRESP != 2'b00;
  - RLAST mismatch, i.e. RLAST on a beat other than BURST_BEATS-1, or missing on beat BURST_BEATS-1.
- When defined, the burst still ends on the received RLAST; data is passed through unmodified.
- When not defined, rd_err is tied 0 and no beat counter for R is built.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, WAIT_SPACE, ADDR_SEND, DATA_RECV);
  - AXI constants (ARSIZE_8B, BURST_INCR, CACHE_BUFFERABLE, RESP_OKAY);
  - frame geometry constants (FRAME_BYTES, BURST_BYTES, LAST_OFFSET).
- One sub-module: sync_fifo_fwft, a single-clock FIFO with a count output; it is shared with future single-clock stages.

Test Plan:
1. Reset, then start with base 0x1000_0000 and an always-ready slave/sink -> 300 AR handshakes at 0x1000_0000 + n*512, last 0x1002_5600; 19200 stream beats; m_sof on beat 0, m_last on beat 19199; one reader_done pulse.
2. m_ready held low after start -> exactly FIFO_DEPTH/64 = 4 bursts issued, then ARVALID stays 0 with no RREADY stall; release m_ready -> remaining bursts resume and data order is preserved.
3. ARREADY delayed 5 cycles -> ARVALID/ARADDR held stable for those cycles; RVALID gapped randomly -> beat count per burst is exactly 64.
4. start pulsed during burst 10 -> ignored, ARADDR sequence unchanged; second start after reader_done -> new frame begins at offset 0.
5. rst_n low mid-burst 150 -> next cycle ARVALID = RREADY = m_valid = busy = 0; a new start fetches from offset 0.
6. READER_ERR_CHECK_EN defined, RRESP = 2'b10 on one beat (or RLAST on beat 62) -> rd_err = 1 and stays high until reset; without the macro, rd_err stays 0.

Source files
------------

// File: rtl/axi4_frame_reader_pkg.sv
// Shared types and constants for the DDR frame reader: FSM encoding, AXI4 read encodings, frame geometry.
package axi4_frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    ADDR_SEND  = 2'd2,
    DATA_RECV  = 2'd3
  } state_t;

  localparam logic [2:0] ARSIZE_8B        = 3'b011;
  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [3:0] CACHE_BUFFERABLE = 4'b0011;
  localparam logic [1:0] RESP_OKAY        = 2'b00;

  localparam int FRAME_BYTES = 153600;
  localparam int BURST_BYTES = 512;
  localparam int LAST_OFFSET = FRAME_BYTES - BURST_BYTES;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count; head is combinational on pop_data.
// Push into a full FIFO or pop from an empty one is dropped; a simultaneous push and pop leaves count unchanged.
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                   clk_100Mhz,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk_100Mhz) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi4_frame_reader.sv
// AXI4 read master: fetches one frame in fixed INCR bursts into a FWFT FIFO and streams it out; first m_valid 1 cycle after the first R beat.
// A burst is issued only when the FIFO can hold all of it, so R is never stalled; define READER_ERR_CHECK_EN for the sticky rd_err checker.
module axi4_frame_reader #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURST_BEATS    = 64,
  parameter int FRAME_BYTES    = axi4_frame_reader_pkg::FRAME_BYTES,
  parameter int FIFO_DEPTH     = 256
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  output logic [2:0]                ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic                      RLAST,
  input  logic [1:0]                RRESP,
  output logic [AXI_DATA_WIDTH-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_sof,
  output logic                      m_last,
  output logic                      busy,
  output logic                      reader_done,
  output logic                      rd_err
);

  import axi4_frame_reader_pkg::*;

  localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
  localparam int BURST_SZ    = BURST_BEATS * BEAT_BYTES;
  localparam int LAST_OFF    = FRAME_BYTES - BURST_SZ;
  localparam int FRAME_BEATS = FRAME_BYTES / BEAT_BYTES;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int BW          = $clog2(FRAME_BEATS);

  state_t                    state;
  state_t                    state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] base;
  logic [AXI_ADDR_WIDTH-1:0] offset;
  logic [CW-1:0]             fifo_count;
  logic                      fifo_empty;
  logic                      space_ok;
  logic                      push;
  logic                      pop;
  logic                      burst_end;
  logic                      frame_end;
  logic [BW-1:0]             beat_cnt;

  assign ARLEN   = 8'(BURST_BEATS - 1);
  assign ARSIZE  = ARSIZE_8B;
  assign ARBURST = BURST_INCR;
  assign ARCACHE = CACHE_BUFFERABLE;
  assign ARPROT  = 3'b000;

  assign space_ok  = (FIFO_DEPTH - int'(fifo_count)) >= BURST_BEATS;
  assign push      = RREADY && RVALID;
  assign burst_end = push && RLAST;
  assign frame_end = burst_end && (offset == AXI_ADDR_WIDTH'(LAST_OFF));
  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign m_sof     = m_valid && (beat_cnt == '0);
  assign m_last    = m_valid && (beat_cnt == BW'(FRAME_BEATS - 1));

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start)     state_nxt = WAIT_SPACE;
      WAIT_SPACE: if (space_ok)  state_nxt = ADDR_SEND;
      ADDR_SEND:  if (ARREADY)   state_nxt = DATA_RECV;
      DATA_RECV:  if (burst_end) state_nxt = frame_end ? IDLE : WAIT_SPACE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE:      busy    = 1'b0;
      ADDR_SEND: ARVALID = 1'b1;
      DATA_RECV: RREADY  = 1'b1;
      default:   ;
    endcase
  end

  // ARADDR is loaded once per burst and then held until the AR handshake.
  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      base        <= '0;
      offset      <= '0;
      ARADDR      <= '0;
      reader_done <= 1'b0;
    end else begin
      reader_done <= frame_end;
      case (state)
        IDLE:       if (start) begin
                      base   <= FRAME_BASE_ADDR;
                      offset <= '0;
                    end
        WAIT_SPACE: if (space_ok) ARADDR <= base + offset;
        DATA_RECV:  if (burst_end && !frame_end) offset <= offset + AXI_ADDR_WIDTH'(BURST_SZ);
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n)                                       beat_cnt <= '0;
    else if (pop && beat_cnt == BW'(FRAME_BEATS - 1)) beat_cnt <= '0;
    else if (pop)                                     beat_cnt <= beat_cnt + BW'(1);
  end

  sync_fifo_fwft #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (RDATA),
    .pop        (pop),
    .pop_data   (m_data),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

`ifdef READER_ERR_CHECK_EN
  localparam int RBW = $clog2(BURST_BEATS);

  logic [RBW-1:0] r_beat;
  logic           err_hit;

  assign err_hit = (RRESP != RESP_OKAY) || (RLAST != (r_beat == RBW'(BURST_BEATS - 1)));

  // The burst still ends on whatever RLAST arrives; the checker only flags it.
  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      r_beat <= '0;
      rd_err <= 1'b0;
    end else if (push) begin
      r_beat <= RLAST ? '0 : r_beat + RBW'(1);
      if (err_hit) rd_err <= 1'b1;
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^RRESP;
  assign rd_err       = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_frame_reader.sv
// Bench for axi4_frame_reader: random AXI slave and stream sink, scoreboarded AR addresses and stream beats.
`timescale 1ns/1ps
module tb_axi4_frame_reader;
  import axi4_frame_reader_pkg::*;

  localparam int FRAME_BEATS = 19200;
  localparam int BURSTS      = 300;
  localparam int BEATS       = 64;
  localparam int DEPTH       = 256;
`ifdef READER_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic        sof;
    logic        last;
  } beat_t;

  logic        clk_100Mhz;
  logic        rst_n, start;
  logic [31:0] FRAME_BASE_ADDR, ARADDR;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST, RRESP;
  logic [3:0]  ARCACHE;
  logic [63:0] RDATA, m_data;
  logic        m_valid, m_ready, m_sof, m_last, busy, reader_done, rd_err;

  axi4_frame_reader dut (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .start(start), .FRAME_BASE_ADDR(FRAME_BASE_ADDR),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .RDATA(RDATA), .RVALID(RVALID),
    .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_sof(m_sof), .m_last(m_last), .busy(busy), .reader_done(reader_done),
    .rd_err(rd_err)
  );

  initial clk_100Mhz = 1'b0;
  always #5 clk_100Mhz = ~clk_100Mhz;

  int vectors = 0, errors = 0;
  int ar_cnt = 0, done_cnt = 0, pop_cnt = 0, served = 0;
  int sink_mode = 0, ar_delay = 0, err_burst = -1;
  bit r_gap = 1'b0;
  logic [31:0] last_ar = '0;
  beat_t       exp_s[$];
  logic [31:0] exp_ar[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // DDR contents: each 8-byte word is a fixed scramble of its own byte address.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a * 32'h9E37_79B1, a ^ 32'hA5A5_5A5A};
  endfunction

  // Reference: a frame is FRAME_BEATS consecutive words from base, requested as BURSTS bursts of 512 bytes.
  task automatic expect_frame(input logic [31:0] base);
    for (int i = 0; i < FRAME_BEATS; i++)
      exp_s.push_back('{d: mem_word(base + 32'(i * 8)), sof: (i == 0), last: (i == FRAME_BEATS - 1)});
    for (int n = 0; n < BURSTS; n++)
      exp_ar.push_back(base + 32'(n * BURST_BYTES));
  endtask

  // Stream sink
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk_100Mhz); #1;
      case (sink_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // AXI read slave
  initial begin : slave
    logic [31:0] bq[$];
    logic [31:0] ara;
    int  beat, wait_cnt;
    bit  arf, rf;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = RESP_OKAY;
    beat = 0; wait_cnt = 0;
    forever begin
      @(negedge clk_100Mhz);
      arf = ARVALID && ARREADY;
      rf  = RVALID && RREADY;
      ara = ARADDR;
      @(posedge clk_100Mhz); #1;
      if (!rst_n) begin
        bq.delete();
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = RESP_OKAY;
        beat = 0; wait_cnt = 0;
      end else begin
        if (arf) begin
          bq.push_back(ara);
          served++;
          ARREADY  = 1'b0;
          wait_cnt = 0;
        end else if (ARVALID && !ARREADY) begin
          if (wait_cnt >= ar_delay) ARREADY = 1'b1;
          else wait_cnt++;
        end
        if (rf) begin
          beat++;
          if (beat == BEATS) begin
            void'(bq.pop_front());
            beat = 0;
          end
        end
        if (RVALID && !rf) begin
          // AXI: hold the beat until it is taken
        end else if (bq.size() > 0 && (!r_gap || $urandom_range(0, 3) != 0)) begin
          RVALID = 1'b1;
          RDATA  = mem_word(bq[0] + 32'(beat * 8));
          RLAST  = (beat == BEATS - 1);
          RRESP  = (served == err_burst && beat == 7) ? 2'b10 : RESP_OKAY;
        end else begin
          RVALID = 1'b0; RLAST = 1'b0; RRESP = RESP_OKAY;
        end
      end
    end
  end

  // Monitor and scoreboard
  initial begin : monitor
    int pending;
    bit p_arv, p_fire;
    logic [31:0] p_ara;
    beat_t e;
    pending = 0; p_arv = 1'b0; p_fire = 1'b0; p_ara = '0;
    forever begin
      @(negedge clk_100Mhz);
      if (!rst_n) begin
        pending = 0; p_arv = 1'b0; p_fire = 1'b0;
        continue;
      end
      if (p_arv && !p_fire) begin
        check("ar_hold_valid", ARVALID, 1);
        check("ar_hold_addr", ARADDR, p_ara);
      end
      if (ARVALID && ARREADY) begin
        check("ar_one_outstanding", pending, 0);
        pending = BEATS;
        ar_cnt++;
        last_ar = ARADDR;
        if (exp_ar.size() == 0) check("ar_unexpected", ARADDR, 0);
        else check("ar_addr", ARADDR, exp_ar.pop_front());
      end
      if (RVALID) check("rready_stall", RREADY, 1);
      if (RVALID && RREADY) pending--;
      if (reader_done) done_cnt++;
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (exp_s.size() == 0) check("stream_extra", m_data, 0);
        else begin
          e = exp_s.pop_front();
          check("stream_data", m_data, e.d);
          check("stream_sof_last", {m_sof, m_last}, {e.sof, e.last});
        end
      end
      p_arv = ARVALID; p_ara = ARADDR; p_fire = ARVALID && ARREADY;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_100Mhz); #1; end
  endtask

  task automatic start_frame(input logic [31:0] base);
    expect_frame(base);
    FRAME_BASE_ADDR = base;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_ar(input int target, input int budget);
    int n = 0;
    while (ar_cnt < target && n < budget) begin cyc(1); n++; end
    check("ar_wait_in_time", ar_cnt >= target, 1);
  endtask

  task automatic finish_frame(input string tag, input int d0, input int a0, input logic exp_err);
    int n = 0;
    while (done_cnt == d0 && n < 60000) begin cyc(1); n++; end
    check({tag, "_done_in_time"}, done_cnt > d0, 1);
    n = 0;
    while (exp_s.size() != 0 && n < 4000) begin cyc(1); n++; end
    cyc(4);
    check({tag, "_drained"}, exp_s.size(), 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_ar_count"}, ar_cnt - a0, BURSTS);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_m_valid_low"}, m_valid, 0);
    check({tag, "_rd_err"}, rd_err, exp_err);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0, d0, p0;
    rst_n = 1'b0; start = 1'b0; FRAME_BASE_ADDR = '0;
    cyc(3);
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", reader_done, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_sof_last", {m_sof, m_last}, 2'b00);
    check("rst_araddr", ARADDR, 0);
    check("arlen", ARLEN, BEATS - 1);
    check("arsize", ARSIZE, 3'b011);
    check("arburst_cache_prot", {ARBURST, ARCACHE, ARPROT}, {2'b01, 4'b0011, 3'b000});
    rst_n = 1'b1;
    cyc(2);

    // Frame A: always-ready slave and sink
    a0 = ar_cnt; d0 = done_cnt;
    start_frame(32'h1000_0000);
    finish_frame("frameA", d0, a0, 1'b0);
    check("frameA_last_ar", last_ar, 32'h1000_0000 + 32'(LAST_OFFSET));

    // Frame B: sink stalled, slow AR, gapped R, stray start, one error response
    sink_mode = 1; ar_delay = 5; r_gap = 1'b1; err_burst = served + 20;
    a0 = ar_cnt; d0 = done_cnt;
    start_frame(32'h1100_0000);
    cyc(1500);
    check("stall_bursts", ar_cnt - a0, DEPTH / BEATS);
    check("stall_arvalid", ARVALID, 0);
    check("stall_m_valid", m_valid, 1);
    sink_mode = 2;
    wait_ar(a0 + 10, 4000);
    FRAME_BASE_ADDR = 32'hDEAD_0000;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    finish_frame("frameB", d0, a0, ERR_EN);

    // Frame C: reset in the middle of burst 150, then restart
    sink_mode = 0; ar_delay = 0; r_gap = 1'b0;
    a0 = ar_cnt;
    start_frame(32'h2000_0000);
    wait_ar(a0 + 150, 20000);
    cyc(20);
    rst_n = 1'b0;
    cyc(1);
    check("midrst_arvalid", ARVALID, 0);
    check("midrst_rready", RREADY, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_err", rd_err, 0);
    exp_s.delete();
    exp_ar.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    a0 = ar_cnt; p0 = pop_cnt;
    start_frame(32'h2400_0000);
    wait_ar(a0 + 5, 3000);
    cyc(50);
    check("restart_stream_beats", pop_cnt - p0 >= 4 * BEATS, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
